// File: rtl/alu_control_md.sv
// ALU control decode plus an iterative unsigned multiply/divide sequencer with HI/LO.
// Operation results land in HI/LO only on the final iteration; md_busy stalls the pipe meanwhile.
module alu_control_md #(
  parameter int WIDTH    = 32,
  parameter int FUN_SIZE = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          ALUOp,
  input  logic [FUN_SIZE-1:0] Functfield,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  output logic [3:0]          aluCTRL,
  output logic                illegal,
  output logic                md_busy,
  output logic                hilo_sel,
  output logic [WIDTH-1:0]    hilo_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  hi_r, lo_r;
  logic [WIDTH-1:0]  acc_hi_r, acc_lo_r, opnd_r;
  logic              md_busy_r;

  logic [5:0]        funct_s;
  logic [3:0]        aluctrl_s;
  logic              illegal_s, hilo_sel_s, is_mult_s, is_div_s;
  logic              accept_s, done_s;
  logic [WIDTH:0]    mul_sum_s, div_shift_s;
  logic [WIDTH-1:0]  div_diff_s, step_hi_s, step_lo_s;
  logic              div_ok_s;

  assign funct_s = Functfield[5:0];

  // Funct/ALUOp decode into the ALU control word and sequencer requests
  always_comb begin
    aluctrl_s  = 4'b1111;
    illegal_s  = 1'b1;
    hilo_sel_s = 1'b0;
    is_mult_s  = 1'b0;
    is_div_s   = 1'b0;
    case (ALUOp)
      2'b00: begin aluctrl_s = 4'b0010; illegal_s = 1'b0; end
      2'b01: begin aluctrl_s = 4'b0110; illegal_s = 1'b0; end
      2'b10: begin
        case (funct_s)
          F_ADD:   begin aluctrl_s = 4'b0010; illegal_s = 1'b0; end
          F_SUB:   begin aluctrl_s = 4'b0110; illegal_s = 1'b0; end
          F_AND:   begin aluctrl_s = 4'b0000; illegal_s = 1'b0; end
          F_OR:    begin aluctrl_s = 4'b0001; illegal_s = 1'b0; end
          F_NOR:   begin aluctrl_s = 4'b1100; illegal_s = 1'b0; end
          F_SLT:   begin aluctrl_s = 4'b0111; illegal_s = 1'b0; end
          F_MULTU: begin aluctrl_s = 4'b0010; illegal_s = 1'b0; is_mult_s = 1'b1; end
          F_DIVU:  begin aluctrl_s = 4'b0010; illegal_s = 1'b0; is_div_s = 1'b1; end
          F_MFHI, F_MFLO: begin aluctrl_s = 4'b0010; illegal_s = 1'b0; hilo_sel_s = 1'b1; end
          default: begin aluctrl_s = 4'b1111; illegal_s = 1'b1; end
        endcase
      end
      default: begin aluctrl_s = 4'b1111; illegal_s = 1'b1; end
    endcase
  end

  assign accept_s  = in_valid && (is_mult_s || is_div_s) && (state_r == IDLE);
  assign done_s    = (state_r != IDLE) && (cnt_r == CNT_LAST);
  assign aluCTRL   = aluctrl_s;
  assign illegal   = illegal_s;
  assign hilo_sel  = hilo_sel_s;
  assign md_busy   = md_busy_r;
  assign hilo_data = (funct_s == F_MFLO) ? lo_r : hi_r;

  // Sequencer next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = is_mult_s ? MUL : DIV;
        else          state_nxt_s = IDLE;
      end
      MUL, DIV: begin
        if (cnt_r == CNT_LAST) state_nxt_s = IDLE;
        else                   state_nxt_s = state_r;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // One iteration: shift-add for MUL, restoring subtract for DIV.
  // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_ok_s    = (div_shift_s >= {1'b0, opnd_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
    step_hi_s   = acc_hi_r;
    step_lo_s   = acc_lo_r;
    case (state_r)
      MUL: begin
        step_hi_s = mul_sum_s[WIDTH:1];
        step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
      end
      DIV: begin
        if (div_ok_s) begin
          step_hi_s = div_diff_s;
          step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
        end else begin
          step_hi_s = div_shift_s[WIDTH-1:0];
          step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        step_hi_s = acc_hi_r;
        step_lo_s = acc_lo_r;
      end
    endcase
  end

  // Operand capture, iteration registers, counter, busy flag and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= {CW{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      acc_hi_r  <= {WIDTH{1'b0}};
      acc_lo_r  <= {WIDTH{1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      md_busy_r <= 1'b0;
    end else if (state_r == IDLE) begin
      if (accept_s) begin
        acc_hi_r  <= {WIDTH{1'b0}};
        acc_lo_r  <= is_mult_s ? op_b : op_a;
        opnd_r    <= is_mult_s ? op_a : op_b;
        cnt_r     <= {CW{1'b0}};
        md_busy_r <= 1'b1;
      end
    end else begin
      acc_hi_r <= step_hi_s;
      acc_lo_r <= step_lo_s;
      if (done_s) begin
        hi_r      <= step_hi_s;
        lo_r      <= step_lo_s;
        cnt_r     <= {CW{1'b0}};
        md_busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// Randomised self-checking bench for alu_control_md at WIDTH=32 and WIDTH=8,
// compared against an arithmetic reference model of decode, multiply and divide.
module tb_alu_control_md;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        in_valid;
  logic [31:0] op_a, op_b;
  logic [3:0]  alu_ctrl;
  logic        illegal, md_busy, hilo_sel;
  logic [31:0] hilo_data;

  logic [1:0]  alu_op8;
  logic [5:0]  funct8;
  logic        in_valid8;
  logic [7:0]  op_a8, op_b8;
  logic [3:0]  alu_ctrl8;
  logic        illegal8, md_busy8, hilo_sel8;
  logic [7:0]  hilo_data8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_control_md #(.WIDTH(32), .FUN_SIZE(6)) dut (
    .clk(clk), .reset(reset), .ALUOp(alu_op), .Functfield(funct), .in_valid(in_valid),
    .op_a(op_a), .op_b(op_b), .aluCTRL(alu_ctrl), .illegal(illegal), .md_busy(md_busy),
    .hilo_sel(hilo_sel), .hilo_data(hilo_data)
  );

  alu_control_md #(.WIDTH(8), .FUN_SIZE(6)) dut8 (
    .clk(clk), .reset(reset), .ALUOp(alu_op8), .Functfield(funct8), .in_valid(in_valid8),
    .op_a(op_a8), .op_b(op_b8), .aluCTRL(alu_ctrl8), .illegal(illegal8), .md_busy(md_busy8),
    .hilo_sel(hilo_sel8), .hilo_data(hilo_data8)
  );

  // Reference decode: table of legal R-type functs and their control words
  function automatic void decode_ref(input logic [1:0] op, input logic [5:0] f,
                                     output logic [3:0] ctrl, output logic ill, output logic hs);
    logic [5:0] fn_tab [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                                6'b101010, 6'b011001, 6'b011011, 6'b010000, 6'b010010};
    logic [3:0] ct_tab [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100,
                                4'b0111, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
    ctrl = 4'b1111; ill = 1'b1; hs = 1'b0;
    if (op == 2'b00) begin ctrl = 4'b0010; ill = 1'b0; end
    else if (op == 2'b01) begin ctrl = 4'b0110; ill = 1'b0; end
    else if (op == 2'b10) begin
      for (int i = 0; i < 10; i++)
        if (fn_tab[i] == f) begin ctrl = ct_tab[i]; ill = 1'b0; hs = (i >= 8); end
    end
  endfunction

  function automatic void md_ref32(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    if (is_mul) begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
    else if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
    else begin hi = a % b; lo = a / b; end
  endfunction

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; alu_op = 2'b10; funct = MULTU; op_a = 32'd7; op_b = 32'd9;
    in_valid8 = 1'b0; alu_op8 = 2'b00; funct8 = 6'd0; op_a8 = 8'd0; op_b8 = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_prio_busy got %b exp 0", md_busy); end
    in_valid = 1'b0; reset = 1'b0;
    alu_op = 2'b10; funct = MFHI; #1;
    checks++;
    if (hilo_data !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hilo_data); end
    funct = MFLO; #1;
    checks++;
    if (hilo_data !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", hilo_data); end
    checks++;
    if (md_busy8 !== 1'b0 || hilo_data8 !== 8'd0) begin
      errors++; $display("FAIL reset_w8 got busy %b data %h exp 0 0", md_busy8, hilo_data8);
    end
    alu_op = 2'b00; funct = 6'd0;
  endtask

  task automatic test_decode;
    logic [3:0] ectrl; logic eill, ehs;
    logic [5:0] sweep [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010,
                               6'b011001, 6'b011011, 6'b010000, 6'b010010, 6'b111111, 6'b000000};
    @(negedge clk);
    in_valid = 1'b0;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 12; i++) begin
        alu_op = 2'(o); funct = sweep[i]; #1;
        decode_ref(alu_op, funct, ectrl, eill, ehs);
        checks++;
        if (alu_ctrl !== ectrl || illegal !== eill || hilo_sel !== ehs) begin
          errors++;
          $display("FAIL decode op %b fn %b got %b/%b/%b exp %b/%b/%b",
                   alu_op, funct, alu_ctrl, illegal, hilo_sel, ectrl, eill, ehs);
        end
      end
    end
    for (int i = 0; i < 100; i++) begin
      alu_op = 2'($urandom_range(0, 3)); funct = 6'($urandom); #1;
      decode_ref(alu_op, funct, ectrl, eill, ehs);
      checks++;
      if (alu_ctrl !== ectrl || illegal !== eill || hilo_sel !== ehs) begin
        errors++;
        $display("FAIL decode_rand op %b fn %b got %b/%b/%b exp %b/%b/%b",
                 alu_op, funct, alu_ctrl, illegal, hilo_sel, ectrl, eill, ehs);
      end
    end
    alu_op8 = 2'b10; funct8 = 6'b100111; #1;
    checks++;
    if (alu_ctrl8 !== 4'b1100 || illegal8 !== 1'b0) begin
      errors++; $display("FAIL decode_w8 got %b/%b exp 1100/0", alu_ctrl8, illegal8);
    end
    alu_op = 2'b00; funct = 6'd0; alu_op8 = 2'b00; funct8 = 6'd0;
  endtask

  task automatic run_op32(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo; int busy_n;
    md_ref32(is_mul, a, b, ehi, elo);
    @(negedge clk);
    alu_op = 2'b10; funct = is_mul ? MULTU : DIVU; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0;
    busy_n = 0;
    while (md_busy === 1'b1 && busy_n < 200) begin busy_n++; @(negedge clk); end
    checks++;
    if (busy_n != 32) begin errors++; $display("FAIL busy_len %h %h got %0d exp 32", a, b, busy_n); end
    alu_op = 2'b10; funct = MFHI; #1;
    checks++;
    if (hilo_data !== ehi || hilo_sel !== 1'b1) begin
      errors++; $display("FAIL hi mul=%0d a=%h b=%h got %h exp %h", is_mul, a, b, hilo_data, ehi);
    end
    funct = MFLO; #1;
    checks++;
    if (hilo_data !== elo || hilo_sel !== 1'b1) begin
      errors++; $display("FAIL lo mul=%0d a=%h b=%h got %h exp %h", is_mul, a, b, hilo_data, elo);
    end
    alu_op = 2'b00; funct = 6'd0;
  endtask

  task automatic test_directed;
    run_op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op32(1'b0, 32'd100, 32'd7);
    run_op32(1'b0, 32'd5, 32'd0);
  endtask

  task automatic test_random_md;
    logic [31:0] a, b; bit m;
    for (int i = 0; i < 14; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 1000));
        2: b = 32'd0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op32(m, a, b);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b, ehi, elo; int busy_n;
    a = $urandom; b = $urandom;
    md_ref32(1'b1, a, b, ehi, elo);
    @(negedge clk);
    alu_op = 2'b10; funct = MULTU; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd4;
    busy_n = 0;
    while (md_busy === 1'b1 && busy_n < 200) begin busy_n++; @(negedge clk); end
    checks++;
    if (busy_n != 32) begin errors++; $display("FAIL b2b_first_len got %0d exp 32", busy_n); end
    checks++;
    if (hilo_data !== ehi) begin errors++; $display("FAIL b2b_first_hi got %h exp %h", hilo_data, ehi); end
    funct = MFLO; #1;
    checks++;
    if (hilo_data !== elo) begin errors++; $display("FAIL b2b_first_lo got %h exp %h", hilo_data, elo); end
    funct = MULTU;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", md_busy); end
    in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0;
    busy_n = 0;
    while (md_busy === 1'b1 && busy_n < 200) begin busy_n++; @(negedge clk); end
    checks++;
    if (busy_n != 32) begin errors++; $display("FAIL b2b_second_len got %0d exp 32", busy_n); end
    alu_op = 2'b10; funct = MFHI; #1;
    checks++;
    if (hilo_data !== 32'd0) begin errors++; $display("FAIL b2b_second_hi got %h exp 0", hilo_data); end
    funct = MFLO; #1;
    checks++;
    if (hilo_data !== 32'd12) begin errors++; $display("FAIL b2b_second_lo got %h exp 0000000c", hilo_data); end
    alu_op = 2'b00; funct = 6'd0;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    alu_op = 2'b10; funct = MULTU; op_a = $urandom | 32'h1; op_b = $urandom | 32'h1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0;
    repeat (9) @(negedge clk);
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b exp 1", md_busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL midop_abort got busy %b exp 0", md_busy); end
    alu_op = 2'b10; funct = MFHI; #1;
    checks++;
    if (hilo_data !== 32'd0) begin errors++; $display("FAIL midop_hi got %h exp 0", hilo_data); end
    funct = MFLO; #1;
    checks++;
    if (hilo_data !== 32'd0) begin errors++; $display("FAIL midop_lo got %h exp 0", hilo_data); end
    alu_op = 2'b00; funct = 6'd0;
    run_op32(1'b0, 32'd9, 32'd3);
  endtask

  task automatic run_op8(input bit is_mul, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p; logic [7:0] ehi, elo; int busy_n;
    if (is_mul) begin p = {8'd0, a} * {8'd0, b}; ehi = p[15:8]; elo = p[7:0]; end
    else if (b == 8'd0) begin ehi = a; elo = 8'hFF; end
    else begin ehi = a % b; elo = a / b; end
    @(negedge clk);
    alu_op8 = 2'b10; funct8 = is_mul ? MULTU : DIVU; op_a8 = a; op_b8 = b; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0; alu_op8 = 2'b00; funct8 = 6'd0;
    busy_n = 0;
    while (md_busy8 === 1'b1 && busy_n < 100) begin busy_n++; @(negedge clk); end
    checks++;
    if (busy_n != 8) begin errors++; $display("FAIL w8_busy_len got %0d exp 8", busy_n); end
    alu_op8 = 2'b10; funct8 = MFHI; #1;
    checks++;
    if (hilo_data8 !== ehi || hilo_sel8 !== 1'b1) begin
      errors++; $display("FAIL w8_hi a=%h b=%h got %h exp %h", a, b, hilo_data8, ehi);
    end
    funct8 = MFLO; #1;
    checks++;
    if (hilo_data8 !== elo) begin
      errors++; $display("FAIL w8_lo a=%h b=%h got %h exp %h", a, b, hilo_data8, elo);
    end
    alu_op8 = 2'b00; funct8 = 6'd0;
  endtask

  task automatic test_width8;
    run_op8(1'b1, 8'hFF, 8'h02);
    for (int i = 0; i < 6; i++)
      run_op8(1'(i % 2), 8'($urandom), 8'($urandom_range(0, 255)));
  endtask

  initial begin
    fork
      begin
        test_reset;
        test_decode;
        test_directed;
        test_random_md;
        test_back_to_back;
        test_reset_mid_op;
        test_width8;
      end
      begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
